mppt_po_controller: RTL and testbench
=====================================

Name: mppt_po_controller

Overview:
Perturb-and-observe maximum-power-point tracker that sequences the converter datapath. Periodically requests a voltage/current sample pair from the front end and computes instantaneous power. Nudges the PWM duty command up or down to climb the power curve. Sits between the sample-capture logic driven from ui_in and the PWM generator whose state appears on uo_out.

Parameters:
SETTLE_CYCLES, 1000, clock cycles waited after each duty change before sampling (min 1)
STEP, 4, duty increment per perturbation (1..32)
DUTY_MIN, 16, lower duty clamp
DUTY_MAX, 240, upper duty clamp (DUTY_MIN < DUTY_MAX)
DUTY_INIT, 128, duty after reset (DUTY_MIN..DUTY_MAX)
TIMEOUT, 255, max cycles in WAIT for sample_valid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  tracking enable
sample_req  out  1  request a new V/I sample pair, held until accepted
sample_valid  in  1  sample pair valid; accepted only while sample_req=1
v_sample  in  8  unsigned voltage code
i_sample  in  8  unsigned current code
duty  out  8  PWM duty command
dir_up  out  1  current perturbation direction (1 = increasing duty)
power  out  16  last computed power v*i
timeout_err  out  1  sticky: a sample request timed out
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): duty=DUTY_INIT, dir_up=1, power=0, p_prev=0, sample_req=0, timeout_err=0, busy=0, counter=0, state=IDLE.
- States are IDLE, SETTLE, WAIT, COMPUTE and UPDATE.
- IDLE: busy=0, sample_req=0, duty held. When enable=1, go to SETTLE with counter=0.
- enable=0 in any state: next edge goes to IDLE, sample_req=0, timeout_err cleared. duty, dir_up and p_prev are held. No capture is performed on that edge.
- SETTLE: counter increments each cycle. After SETTLE_CYCLES cycles, go to WAIT, assert sample_req and clear the counter.
- WAIT: sample_req=1. The edge with sample_valid=1 latches v_sample/i_sample, clears sample_req and goes to COMPUTE.
  - If TIMEOUT cycles pass without sample_valid: set timeout_err=1, clear sample_req, go to SETTLE. duty and p_prev are unchanged.
- sample_valid outside WAIT is ignored.
- COMPUTE (1 cycle): power <= v*i, as an 8x8 unsigned full 16-bit product.
- UPDATE (1 cycle), direction and duty:
  - If power < p_prev, the direction toggles; otherwise it is kept. Equal power keeps direction.
  - Step in the new direction: duty+STEP if up, duty-STEP if down. Compute in 9 bits to avoid wrap.
  - If the result exceeds DUTY_MAX: duty=DUTY_MAX, dir_up=0.
  - If the result is below DUTY_MIN: duty=DUTY_MIN, dir_up=1.
  - Otherwise duty=result and dir_up=new direction.
  - p_prev <= power. Go to SETTLE with counter=0.
- Latency: accept edge N → power valid after edge N+1 → duty/dir_up valid after edge N+2.
- After reset, p_prev=0, so the first sample always keeps dir_up=1.
- timeout_err stays set until reset or enable=0. A successful capture does not clear it.
- duty changes only in UPDATE. It never leaves DUTY_MIN..DUTY_MAX.

Test Plan:
1. Reset and start: rst_n low then high, enable=1, SETTLE_CYCLES=8 → duty=128, dir_up=1, sample_req=0; sample_req rises after 8 settle cycles; busy=1 from the first enabled cycle.
2. Rising power: supply (v=100,i=50) → power=5000, duty 128→132. Then supply (100,60) → power=6000, duty→136, dir_up stays 1.
3. Falling power: continuing from 2, supply (100,40) → power=4000 < 6000 → dir_up=0, duty 136→132. Then supply (100,40) again (equal power) → dir_up stays 0, duty→128.
4. Clamp: DUTY_INIT=236, STEP=4. Supply (10,10) → duty=240, no clamp. Supply (20,20) → result 244 clamps, duty=240, dir_up=0. Supply (20,20) again → duty=236.
5. Timeout: TIMEOUT=255, never assert sample_valid → after 255 WAIT cycles timeout_err=1, sample_req=0, duty unchanged. The block re-requests after SETTLE. A valid sample then updates duty while timeout_err stays 1.
6. Abort paths:
   - enable=0 during WAIT → next edge IDLE, sample_req=0, timeout_err=0, duty held.
   - rst_n=0 during COMPUTE → outputs at reset values immediately, without waiting for a clock edge.
   - sample_valid pulsed in SETTLE → ignored.

Source files
------------

// File: rtl/mppt_po_controller.sv
// +----------------------------------------------------------------------------+
// | mppt_po_controller                                                         |
// | Perturb-and-observe MPPT: samples V/I, computes power, steps PWM duty.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module mppt_po_controller #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int STEP          = 4,
  parameter int DUTY_MIN      = 16,
  parameter int DUTY_MAX      = 240,
  parameter int DUTY_INIT     = 128,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        sample_req,
  input  logic        sample_valid,
  input  logic [7:0]  v_sample,
  input  logic [7:0]  i_sample,
  output logic [7:0]  duty,
  output logic        dir_up,
  output logic [15:0] power,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPUTE = 3'd3,
    S_UPDATE  = 3'd4
  } state_t;

  localparam int CNT_TOP = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [9:0]    STEP_W       = 10'(STEP);
  localparam logic [9:0]    MIN_W        = 10'(DUTY_MIN);
  localparam logic [9:0]    MAX_W        = 10'(DUTY_MAX);
  localparam logic [7:0]    INIT_W       = 8'(DUTY_INIT);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    v_lat, v_lat_n, i_lat, i_lat_n;
  logic [15:0]   p_prev, p_prev_n, power_n;
  logic [7:0]    duty_n;
  logic          dir_n, terr_n;
  logic          dir_cand;
  logic [9:0]    stepped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      v_lat       <= '0;
      i_lat       <= '0;
      p_prev      <= '0;
      power       <= '0;
      duty        <= INIT_W;
      dir_up      <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      v_lat       <= v_lat_n;
      i_lat       <= i_lat_n;
      p_prev      <= p_prev_n;
      power       <= power_n;
      duty        <= duty_n;
      dir_up      <= dir_n;
      timeout_err <= terr_n;
    end
  end

  // 10-bit signed-style step: bit 9 flags a downward step that went below zero.
  always_comb begin
    dir_cand = (power < p_prev) ? ~dir_up : dir_up;
    stepped  = dir_cand ? ({2'b00, duty} + STEP_W) : ({2'b00, duty} - STEP_W);
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    v_lat_n  = v_lat;
    i_lat_n  = i_lat;
    p_prev_n = p_prev;
    power_n  = power;
    duty_n   = duty;
    dir_n    = dir_up;
    terr_n   = timeout_err;

    if (!enable) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      terr_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_n = S_WAIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (sample_valid) begin
            v_lat_n = v_sample;
            i_lat_n = i_sample;
            state_n = S_COMPUTE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            terr_n  = 1'b1;
            state_n = S_SETTLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          power_n = {8'd0, v_lat} * {8'd0, i_lat};
          state_n = S_UPDATE;
        end
        S_UPDATE: begin
          if (dir_cand && (stepped > MAX_W)) begin
            duty_n = MAX_W[7:0];
            dir_n  = 1'b0;
          end else if (!dir_cand && (stepped[9] || (stepped < MIN_W))) begin
            duty_n = MIN_W[7:0];
            dir_n  = 1'b1;
          end else begin
            duty_n = stepped[7:0];
            dir_n  = dir_cand;
          end
          p_prev_n = power;
          state_n  = S_SETTLE;
          cnt_n    = '0;
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign sample_req = (state == S_WAIT);
  assign busy       = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mppt_po_controller.sv
// +----------------------------------------------------------------------------+
// | tb_mppt_po_controller                                                      |
// | Directed bench with a cycle-level behavioural model; two duty presets.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mppt_po_controller;

  localparam int SETTLE = 8;
  localparam int STEP   = 4;
  localparam int DMIN   = 16;
  localparam int DMAX   = 240;
  localparam int TOUT   = 255;
  localparam int INIT_A = 128;
  localparam int INIT_B = 236;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  v_sample = 8'd0;
  logic [7:0]  i_sample = 8'd0;

  logic        sample_req_a, dir_up_a, timeout_err_a, busy_a;
  logic [7:0]  duty_a;
  logic [15:0] power_a;
  logic        sample_req_b, dir_up_b, timeout_err_b, busy_b;
  logic [7:0]  duty_b;
  logic [15:0] power_b;

  always #5 clk = ~clk;

  mppt_po_controller #(
    .SETTLE_CYCLES(SETTLE), .STEP(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
    .DUTY_INIT(INIT_A), .TIMEOUT(TOUT)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_req(sample_req_a),
    .sample_valid(sample_valid), .v_sample(v_sample), .i_sample(i_sample),
    .duty(duty_a), .dir_up(dir_up_a), .power(power_a),
    .timeout_err(timeout_err_a), .busy(busy_a)
  );

  mppt_po_controller #(
    .SETTLE_CYCLES(SETTLE), .STEP(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
    .DUTY_INIT(INIT_B), .TIMEOUT(TOUT)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_req(sample_req_b),
    .sample_valid(sample_valid), .v_sample(v_sample), .i_sample(i_sample),
    .duty(duty_b), .dir_up(dir_up_b), .power(power_b),
    .timeout_err(timeout_err_b), .busy(busy_b)
  );

  // Model: phase of the P&O loop plus the tracked values for both presets.
  localparam int P_IDLE = 0, P_SETTLE = 1, P_WAIT = 2, P_COMPUTE = 3, P_UPDATE = 4;
  int m_phase, m_elapsed, m_v, m_i, m_power, m_terr;
  int m_duty [2];
  int m_dir  [2];
  int m_prev [2];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_v = 0; m_i = 0; m_power = 0; m_terr = 0;
    m_duty[0] = INIT_A; m_duty[1] = INIT_B;
    for (int k = 0; k < 2; k++) begin
      m_dir[k]  = 1;
      m_prev[k] = 0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (!enable) begin
      m_phase = P_IDLE;
      m_terr  = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin m_phase = P_SETTLE; m_elapsed = 0; end
        P_SETTLE: begin
          m_elapsed++;
          if (m_elapsed == SETTLE) begin m_phase = P_WAIT; m_elapsed = 0; end
        end
        P_WAIT: begin
          if (sample_valid) begin
            m_v = int'(v_sample); m_i = int'(i_sample); m_phase = P_COMPUTE;
          end else begin
            m_elapsed++;
            if (m_elapsed == TOUT) begin m_terr = 1; m_phase = P_SETTLE; m_elapsed = 0; end
          end
        end
        P_COMPUTE: begin m_power = m_v * m_i; m_phase = P_UPDATE; end
        default: begin
          for (int k = 0; k < 2; k++) begin
            int nd, r;
            nd = (m_power < m_prev[k]) ? 1 - m_dir[k] : m_dir[k];
            r  = m_duty[k] + (nd == 1 ? STEP : -STEP);
            if (r > DMAX)      begin m_duty[k] = DMAX; m_dir[k] = 0; end
            else if (r < DMIN) begin m_duty[k] = DMIN; m_dir[k] = 1; end
            else               begin m_duty[k] = r;    m_dir[k] = nd; end
            m_prev[k] = m_power;
          end
          m_phase = P_SETTLE; m_elapsed = 0;
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_a",   sample_req_a,  (m_phase == P_WAIT) ? 1 : 0);
      chk("req_b",   sample_req_b,  (m_phase == P_WAIT) ? 1 : 0);
      chk("busy_a",  busy_a,        (m_phase != P_IDLE) ? 1 : 0);
      chk("busy_b",  busy_b,        (m_phase != P_IDLE) ? 1 : 0);
      chk("terr_a",  timeout_err_a, m_terr);
      chk("terr_b",  timeout_err_b, m_terr);
      chk("power_a", power_a,       m_power);
      chk("power_b", power_b,       m_power);
      chk("duty_a",  duty_a,        m_duty[0]);
      chk("duty_b",  duty_b,        m_duty[1]);
      chk("dir_a",   dir_up_a,      m_dir[0]);
      chk("dir_b",   dir_up_b,      m_dir[1]);
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!sample_req_a && n < 1100) begin
      cycle();
      n++;
    end
    chk("sample_req_reached", sample_req_a, 1);
  endtask

  task automatic give_sample(input int v, input int i);
    wait_req();
    sample_valid = 1'b1;
    v_sample = 8'(v);
    i_sample = 8'(i);
    cycle();
    sample_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic expect_pair(input string tag, input int pw, input int da, input int ra,
                             input int db, input int rb);
    chk({tag, "_power"}, power_a, pw);
    chk({tag, "_duty_a"}, duty_a, da);
    chk({tag, "_dir_a"}, dir_up_a, ra);
    chk({tag, "_duty_b"}, duty_b, db);
    chk({tag, "_dir_b"}, dir_up_b, rb);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    check_en = 1'b1;
    repeat (2) cycle();
    chk("rst_duty_a", duty_a, 128);
    chk("rst_duty_b", duty_b, 236);
    chk("rst_dir", dir_up_a, 1);
    chk("rst_req", sample_req_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_power", power_a, 0);

    rst_n = 1'b1;
    cycle();
    enable = 1'b1;
    cycle();
    chk("start_busy", busy_a, 1);
    repeat (7) cycle();
    chk("settle_req_low", sample_req_a, 0);
    cycle();
    chk("settle_req_high", sample_req_a, 1);

    // Climb, then reverse on a power drop; B sits on the upper clamp.
    give_sample(100, 50); expect_pair("rise1", 5000, 132, 1, 240, 1);
    give_sample(100, 60); expect_pair("rise2", 6000, 136, 1, 240, 0);
    give_sample(100, 40); expect_pair("fall",  4000, 132, 0, 240, 0);
    give_sample(100, 40); expect_pair("equal", 4000, 128, 0, 236, 0);

    wait_req();
    repeat (254) cycle();
    chk("tout_pre_err", timeout_err_a, 0);
    chk("tout_pre_req", sample_req_a, 1);
    cycle();
    chk("tout_err", timeout_err_a, 1);
    chk("tout_req", sample_req_a, 0);
    chk("tout_duty", duty_a, 128);
    give_sample(100, 40); expect_pair("after_tout", 4000, 124, 0, 232, 0);
    chk("tout_sticky", timeout_err_a, 1);

    wait_req();
    enable = 1'b0;
    cycle();
    chk("abort_req", sample_req_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_terr", timeout_err_a, 0);
    chk("abort_duty", duty_a, 124);
    enable = 1'b1;
    cycle();
    sample_valid = 1'b1; v_sample = 8'd1; i_sample = 8'd1;
    cycle();
    cycle();
    sample_valid = 1'b0;
    chk("settle_valid_req", sample_req_a, 0);
    chk("settle_valid_power", power_a, 4000);
    give_sample(100, 50); expect_pair("resume", 5000, 120, 0, 228, 0);

    wait_req();
    sample_valid = 1'b1; v_sample = 8'd50; i_sample = 8'd50;
    cycle();
    sample_valid = 1'b0;
    chk("compute_busy", busy_a, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_duty_a", duty_a, 128);
    chk("arst_duty_b", duty_b, 236);
    chk("arst_dir", dir_up_a, 1);
    chk("arst_power", power_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_req", sample_req_a, 0);
    cycle();
    rst_n = 1'b1;
    repeat (12) cycle();
    chk("post_reset_req", sample_req_a, 1);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
